// File: rtl/psum_pkg.sv
// psum_pkg: shared sizes, drain FSM states and lane extraction for the psum AXIS packer
package psum_pkg;
  localparam int PSUM_W = 1280;
  localparam int LANE_W = 32;
  localparam int BEATS = PSUM_W / LANE_W;
  localparam int BEAT_IDX_W = $clog2(BEATS);
  localparam logic [BEAT_IDX_W-1:0] LAST_BEAT = BEAT_IDX_W'(BEATS - 1);
  typedef enum logic {S_IDLE, S_STREAM} state_t;
  function automatic logic [LANE_W-1:0] lane_sel(input logic [PSUM_W-1:0] v, input logic [BEAT_IDX_W-1:0] i);
    return v[i*LANE_W +: LANE_W];
  endfunction
endpackage

// File: rtl/psum_axis_packer_if.sv
// psum_axis_packer_if: core-side psum handshake plus AXI-Stream master bus; master = packer view, slave = core/DMA view
interface psum_axis_packer_if import psum_pkg::*; #(
  parameter int PSUM_WIDTH = PSUM_W,
  parameter int C_M_AXIS_TDATA_WIDTH = LANE_W
) ();
  logic [PSUM_WIDTH-1:0] psum_in;
  logic psum_valid;
  logic psum_last;
  logic psum_ready;
  logic M_AXIS_TVALID;
  logic [C_M_AXIS_TDATA_WIDTH-1:0] M_AXIS_TDATA;
  logic [C_M_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TSTRB;
  logic M_AXIS_TLAST;
  logic M_AXIS_TREADY;
  modport master (
    input psum_in, psum_valid, psum_last, M_AXIS_TREADY,
    output psum_ready, M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TSTRB, M_AXIS_TLAST
  );
  modport slave (
    output psum_in, psum_valid, psum_last, M_AXIS_TREADY,
    input psum_ready, M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TSTRB, M_AXIS_TLAST
  );
endinterface

// File: rtl/psum_pingpong_buf.sv
// psum_pingpong_buf: two-slot ping-pong store; ports push/push_data in, pop in, occupancy and rd_data (slot at rd_ptr) out
module psum_pingpong_buf import psum_pkg::*; #(
  parameter int W = PSUM_W + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [1:0]   occupancy,
  output logic [W-1:0] rd_data
);
  logic [W-1:0] slot_q [2];
  logic [W-1:0] slot_d [2];
  logic wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0] occ_q, occ_d;
  always_comb begin
    slot_d = slot_q;
    if (push) slot_d[wr_ptr_q] = push_data;
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    occ_d = occ_q + {1'b0, push} - {1'b0, pop};
    occupancy = occ_q;
    rd_data = slot_q[rd_ptr_q];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q <= 2'd0;
    end else begin
      slot_q <= slot_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q <= occ_d;
    end
  end
endmodule

// File: rtl/psum_axis_packer.sv
// psum_axis_packer: buffers psum vectors (bus.psum_*) and streams them lane by lane on bus.M_AXIS_*; relu_en clamps negative lanes, busy/frame_count are status
module psum_axis_packer import psum_pkg::*; #(
  parameter int PSUM_WIDTH = PSUM_W,
  parameter int C_M_AXIS_TDATA_WIDTH = LANE_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   relu_en,
  psum_axis_packer_if.master     bus,
  output logic                   busy,
  output logic [15:0]            frame_count
);
  state_t state_q, state_d;
  logic [BEAT_IDX_W-1:0] beat_q, beat_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic [1:0] occ;
  logic [PSUM_WIDTH:0] rd_data;
  logic [C_M_AXIS_TDATA_WIDTH-1:0] lane;
  logic ready, push, hs, end_beat, streaming;
  psum_pingpong_buf #(.W(PSUM_WIDTH + 1)) u_buf (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(end_beat),
    .push_data({bus.psum_last, bus.psum_in}),
    .occupancy(occ),
    .rd_data(rd_data)
  );
  always_comb begin
    ready = !rst && occ != 2'd2;
    push = bus.psum_valid && ready;
    streaming = state_q == S_STREAM;
    hs = streaming && bus.M_AXIS_TREADY;
    end_beat = hs && beat_q == LAST_BEAT;
    lane = lane_sel(rd_data[PSUM_WIDTH-1:0], beat_q);
    beat_d = end_beat ? '0 : hs ? beat_q + 1'b1 : beat_q;
    frame_count_d = frame_count_q + {15'd0, end_beat && rd_data[PSUM_WIDTH]};
    // a slot written in the same cycle as the last beat keeps the stream going without a bubble
    state_d = !streaming ? (occ != 2'd0 ? S_STREAM : S_IDLE)
            : (end_beat && occ == 2'd1 && !push) ? S_IDLE : S_STREAM;
    bus.psum_ready = ready;
    bus.M_AXIS_TVALID = streaming;
    bus.M_AXIS_TDATA = (!streaming || (relu_en && lane[C_M_AXIS_TDATA_WIDTH-1])) ? '0 : lane;
    bus.M_AXIS_TLAST = streaming && beat_q == LAST_BEAT && rd_data[PSUM_WIDTH];
    bus.M_AXIS_TSTRB = '1;
    busy = occ != 2'd0;
    frame_count = frame_count_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      beat_q <= '0;
      frame_count_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q <= beat_d;
      frame_count_q <= frame_count_d;
    end
  end
endmodule

// File: tb/tb_psum_axis_packer.sv
// tb_psum_axis_packer: directed self-checking bench for psum_axis_packer
module tb_psum_axis_packer;
  typedef struct {
    logic [31:0] d;
    logic        l;
    int          c;
  } beat_t;

  logic clk, rst, relu_en, busy, rnd, rnd_bit, tready;
  logic [15:0] frame_count;
  int n_chk = 0, n_fail = 0, cyc = 0, acc_cyc = 0;
  int a1, a2, a3;
  beat_t q[$];
  beat_t e_q[$];
  logic pv, pl;
  logic [31:0] pd;

  psum_axis_packer_if #(.PSUM_WIDTH(1280), .C_M_AXIS_TDATA_WIDTH(32)) vif ();

  psum_axis_packer dut (
    .clk(clk),
    .rst(rst),
    .relu_en(relu_en),
    .bus(vif),
    .busy(busy),
    .frame_count(frame_count)
  );

  assign vif.M_AXIS_TREADY = rnd ? rnd_bit : tready;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    rnd_bit = 1'($urandom_range(0, 1));
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && vif.M_AXIS_TVALID && vif.M_AXIS_TREADY)
      q.push_back('{vif.M_AXIS_TDATA, vif.M_AXIS_TLAST, cyc});
  end

  always @(negedge clk) begin
    if (!rst && pv)
      check("axis_hold", 64'({vif.M_AXIS_TVALID, vif.M_AXIS_TLAST, vif.M_AXIS_TDATA}), 64'({1'b1, pl, pd}));
    pv = !rst && vif.M_AXIS_TVALID && !vif.M_AXIS_TREADY;
    pd = vif.M_AXIS_TDATA;
    pl = vif.M_AXIS_TLAST;
  end

  function automatic logic [1279:0] mk_seq(input int base);
    logic [1279:0] v;
    for (int k = 0; k < 40; k++) v[32*k +: 32] = 32'(base + k);
    return v;
  endfunction

  function automatic logic [1279:0] mk_alt();
    logic [1279:0] v;
    for (int k = 0; k < 40; k++) v[32*k +: 32] = k[0] ? 32'd7 : 32'hFFFF_FFFB;
    return v;
  endfunction

  task automatic send(input logic [1279:0] v, input logic last);
    logic ok;
    logic [31:0] ln;
    int t;
    ok = 1'b0;
    t = 0;
    vif.psum_in = v;
    vif.psum_last = last;
    vif.psum_valid = 1'b1;
    while (!ok && t < 2000) begin
      @(negedge clk);
      ok = vif.psum_ready;
      @(posedge clk);
      #1;
      t++;
    end
    vif.psum_valid = 1'b0;
    acc_cyc = cyc;
    if (!ok) check("send_timeout", 64'(ok), 64'd1);
    for (int k = 0; k < 40; k++) begin
      ln = v[32*k +: 32];
      e_q.push_back('{(relu_en && ln[31]) ? 32'd0 : ln, last && k == 39, 0});
    end
  endtask

  task automatic drain(input string tag, input int n, input int c0);
    beat_t b, e;
    int t;
    t = 0;
    while (q.size() < n && t < 20000) begin
      @(negedge clk);
      t++;
    end
    if (q.size() < n) begin
      check({tag, "_timeout"}, 64'(q.size()), 64'(n));
    end else begin
      for (int i = 0; i < n; i++) begin
        b = q.pop_front();
        e = e_q.pop_front();
        check({tag, "_tdata"}, 64'(b.d), 64'(e.d));
        check({tag, "_tlast"}, 64'(b.l), 64'(e.l));
        if (c0 >= 0) check({tag, "_cycle"}, 64'(b.c), 64'(c0 + i));
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    relu_en = 1'b0;
    rnd = 1'b0;
    tready = 1'b0;
    pv = 1'b0;
    vif.psum_in = '0;
    vif.psum_valid = 1'b0;
    vif.psum_last = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_tvalid", 64'(vif.M_AXIS_TVALID), 64'd0);
    check("rst_tdata", 64'(vif.M_AXIS_TDATA), 64'd0);
    check("rst_tlast", 64'(vif.M_AXIS_TLAST), 64'd0);
    check("rst_psum_ready", 64'(vif.psum_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_frame_count", 64'(frame_count), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_psum_ready", 64'(vif.psum_ready), 64'd1);
    check("tstrb", 64'(vif.M_AXIS_TSTRB), 64'hF);
    @(posedge clk);
    #1;
    // T1: lanes 1..40, one frame, TREADY high
    tready = 1'b1;
    send(mk_seq(1), 1'b1);
    @(negedge clk);
    check("t1_tvalid_n", 64'(vif.M_AXIS_TVALID), 64'd0);
    check("t1_busy", 64'(busy), 64'd1);
    @(negedge clk);
    check("t1_tvalid_n1", 64'(vif.M_AXIS_TVALID), 64'd1);
    check("t1_first_tdata", 64'(vif.M_AXIS_TDATA), 64'd1);
    check("t1_first_tlast", 64'(vif.M_AXIS_TLAST), 64'd0);
    drain("t1", 40, acc_cyc + 1);
    repeat (2) @(negedge clk);
    check("t1_frame_count", 64'(frame_count), 64'd1);
    check("t1_idle_busy", 64'(busy), 64'd0);
    check("t1_idle_tvalid", 64'(vif.M_AXIS_TVALID), 64'd0);
    @(posedge clk);
    #1;
    // T2: ReLU on then off over -5/+7 lanes
    relu_en = 1'b1;
    send(mk_alt(), 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("t2_relu_lane0", 64'(vif.M_AXIS_TDATA), 64'd0);
    drain("t2_relu", 40, -1);
    repeat (2) @(posedge clk);
    #1;
    relu_en = 1'b0;
    send(mk_alt(), 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("t2_raw_lane0", 64'(vif.M_AXIS_TDATA), 64'hFFFF_FFFB);
    drain("t2_raw", 40, -1);
    repeat (2) @(negedge clk);
    check("t2_frame_count", 64'(frame_count), 64'd1);
    @(posedge clk);
    #1;
    // T3: three back-to-back vectors, no gap across 120 beats
    send(mk_seq(100), 1'b0);
    a1 = acc_cyc;
    send(mk_seq(200), 1'b0);
    a2 = acc_cyc;
    check("t3_second_accept", 64'(a2), 64'(a1 + 1));
    @(negedge clk);
    check("t3_full_ready", 64'(vif.psum_ready), 64'd0);
    send(mk_seq(300), 1'b1);
    a3 = acc_cyc;
    check("t3_third_accept", 64'(a3), 64'(a1 + 42));
    drain("t3", 120, a1 + 1);
    repeat (2) @(negedge clk);
    check("t3_frame_count", 64'(frame_count), 64'd2);
    @(posedge clk);
    #1;
    // T4: random back-pressure over four vectors
    rnd = 1'b1;
    send(mk_seq(400), 1'b0);
    send(mk_seq(500), 1'b1);
    send(mk_seq(600), 1'b0);
    send(mk_seq(700), 1'b1);
    drain("t4", 160, -1);
    rnd = 1'b0;
    repeat (3) @(negedge clk);
    check("t4_frame_count", 64'(frame_count), 64'd4);
    check("t4_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    // T5: reset at beat 17 with both slots full
    tready = 1'b0;
    send(mk_seq(800), 1'b1);
    send(mk_seq(900), 1'b0);
    tready = 1'b1;
    for (int t = 0; t < 200 && q.size() < 17; t++) begin
      @(posedge clk);
      #1;
    end
    tready = 1'b0;
    @(negedge clk);
    check("t5_beat17", 64'(vif.M_AXIS_TDATA), 64'd817);
    check("t5_busy_pre", 64'(busy), 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("t5_tvalid_async", 64'(vif.M_AXIS_TVALID), 64'd0);
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_frame_count", 64'(frame_count), 64'd0);
    check("t5_ready_in_rst", 64'(vif.psum_ready), 64'd0);
    q.delete();
    e_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    tready = 1'b1;
    send(mk_seq(1000), 1'b1);
    drain("t5_after", 40, acc_cyc + 1);
    repeat (2) @(negedge clk);
    check("t5_after_frame_count", 64'(frame_count), 64'd1);
    @(posedge clk);
    #1;
    // T6: frame_count wrap from 16'hFFFF
    force dut.frame_count_q = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.frame_count_q;
    @(negedge clk);
    check("t6_preset", 64'(frame_count), 64'hFFFF);
    @(posedge clk);
    #1;
    send(mk_seq(1), 1'b1);
    drain("t6", 40, acc_cyc + 1);
    repeat (2) @(negedge clk);
    check("t6_wrap", 64'(frame_count), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
